// File: rtl/div_pkg.sv
// div_pkg -- shared types and constants for seq_array_divider.
//   div_state_e : controller states (IDLE, CALC, DONE)
//   DIV_W       : default operand width
//   cnt_w()     : step-counter width for a W-bit divider
//   DIV_DBZ_Q   : quotient reported on divide-by-zero (all ones)
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DIV_W = 8;

  localparam logic [DIV_W-1:0] DIV_DBZ_Q = '1;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step -- one combinational restoring-division step.
//   rem_shift : partial remainder already shifted left with the next dividend bit (W+1 bits)
//   divisor   : denominator
//   rem_next  : restored/subtracted remainder (always < divisor, so W bits suffice)
//   q_bit     : quotient bit produced by this step
module div_step #(
  parameter int W = 8
) (
  input  logic [W:0]   rem_shift,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);

  logic [W:0] dvsr_ext;

  assign dvsr_ext = {1'b0, divisor};
  assign q_bit    = (rem_shift >= dvsr_ext);
  assign rem_next = q_bit ? W'(rem_shift - dvsr_ext) : rem_shift[W-1:0];

endmodule

// File: rtl/seq_array_divider.sv
// seq_array_divider -- iterative restoring divider, one quotient bit per clock.
//   clk, rst     : clock, synchronous active-high reset
//   ena          : clock enable; all state holds while low
//   start        : request; accepted in IDLE or DONE when ena is high
//   dividend     : numerator, captured on accept
//   divisor      : denominator, captured on accept
//   quotient     : registered result, updated only on completion
//   remainder    : registered result, updated only on completion
//   busy         : high while iterating
//   done         : high for one enabled cycle when results become valid
//   div_by_zero  : flags a zero divisor; held until the next accept
// Build option: define DIV_SIGNED_EN for two's-complement operands with
// truncating division (remainder takes the dividend's sign).
module seq_array_divider
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int CW = cnt_w(W);

  div_state_e      state, state_nx;
  logic [W-1:0]    r, q, dvsr;
  logic [CW-1:0]   cnt;
  logic [W:0]      rem_shift;
  logic [W-1:0]    rem_next, q_next;
  logic            q_bit;
  logic            accept, last, dbz_in;
  logic [W-1:0]    a_in, b_in;
  logic [W-1:0]    q_fix, r_fix;

  assign accept = ena && start && (state != CALC);
  assign last   = (cnt == CW'(W - 1));
  assign dbz_in = (divisor == '0);

`ifdef DIV_SIGNED_EN
  // Magnitudes go through the unsigned datapath; signs are reapplied on the
  // completion edge so latency matches the unsigned build.
  logic neg_q, neg_r;
  assign a_in  = dividend[W-1] ? -dividend : dividend;
  assign b_in  = divisor[W-1]  ? -divisor  : divisor;
  assign q_fix = neg_q ? -q_next   : q_next;
  assign r_fix = neg_r ? -rem_next : rem_next;
`else
  assign a_in  = dividend;
  assign b_in  = divisor;
  assign q_fix = q_next;
  assign r_fix = rem_next;
`endif

  // {R,Q} shift left: the dividend MSB still sitting in Q moves into R.
  assign rem_shift = {r, q[W-1]};
  assign q_next    = {q[W-2:0], q_bit};

  div_step #(.W(W)) u_step (
    .rem_shift (rem_shift),
    .divisor   (dvsr),
    .rem_next  (rem_next),
    .q_bit     (q_bit)
  );

  always_comb begin
    state_nx = state;
    if (ena) begin
      case (state)
        IDLE:    if (start) state_nx = dbz_in ? DONE : CALC;
        CALC:    if (last)  state_nx = DONE;
        DONE:    state_nx = start ? (dbz_in ? DONE : CALC) : IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      r           <= '0;
      q           <= '0;
      dvsr        <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (accept) begin
        r           <= '0;
        q           <= a_in;
        dvsr        <= b_in;
        cnt         <= '0;
        div_by_zero <= dbz_in;
`ifdef DIV_SIGNED_EN
        neg_q       <= dividend[W-1] ^ divisor[W-1];
        neg_r       <= dividend[W-1];
`endif
        // Zero divisor completes on the accept edge itself.
        if (dbz_in) begin
          quotient  <= '1;
          remainder <= dividend;
        end
      end else if (ena && state == CALC) begin
        r   <= rem_next;
        q   <= q_next;
        cnt <= cnt + CW'(1);
        if (last) begin
          quotient  <= q_fix;
          remainder <= r_fix;
        end
      end
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_array_divider.sv
module tb_seq_array_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, ena, start;
  logic [W-1:0] dividend, divisor;
  logic [W-1:0] quotient, remainder;
  logic         busy, done, div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_array_divider #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain arithmetic on the operands.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] eq, output logic [W-1:0] er,
                                output logic ez);
    int sa, sb;
    ez = (b == 0);
    if (b == 0) begin
      eq = '1;
      er = a;
    end else begin
`ifdef DIV_SIGNED_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
`else
      sa = int'(a);
      sb = int'(b);
`endif
      eq = W'(sa / sb);
      er = W'(sa % sb);
    end
  endfunction

  // Accept a start on the next edge; leaves start low afterwards.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  // Wait for done; lat counts edges after the accept edge. rnd_ena stalls randomly.
  task automatic wait_done(input string tag, input bit rnd_ena, output int lat);
    lat = 0;
    while (!done && lat < 60) begin
      if (rnd_ena) ena = ($urandom_range(0, 3) != 0);
      step();
      lat++;
    end
    ena = 1'b1;
    if (!done) chk({tag, "_timeout"}, 32'(done), 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eq, er;
    logic ez;
    model(a, b, eq, er, ez);
    chk({tag, "_q"},   32'(quotient),    32'(eq));
    chk({tag, "_r"},   32'(remainder),   32'(er));
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
  endtask

  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    launch(a, b);
    chk({tag, "_busy0"}, 32'(busy), (b == 0) ? 32'd0 : 32'd1);
    wait_done(tag, 1'b0, lat);
    chk({tag, "_lat"}, 32'(lat), (b == 0) ? 32'd0 : 32'(W));
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    check_result(tag, a, b);
    step();
    chk({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    logic [W-1:0] a, b;
    rst = 1'b1; ena = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    step(); step();
    chk("rst_q",    32'(quotient),    32'd0);
    chk("rst_r",    32'(remainder),   32'd0);
    chk("rst_busy", 32'(busy),        32'd0);
    chk("rst_done", 32'(done),        32'd0);
    chk("rst_dbz",  32'(div_by_zero), 32'd0);
    rst = 1'b0; ena = 1'b1;
    step();

    // 200/7: busy for W cycles
    launch(8'd200, 8'd7);
    for (int k = 0; k < W; k++) begin
      chk("busy_span", 32'(busy), 32'd1);
      chk("no_early_done", 32'(done), 32'd0);
      if (k < W - 1) step();
    end
    wait_done("d200_7", 1'b0, lat);
    chk("d200_7_lat", 32'(lat), 32'd1);
    chk("d200_7_q", 32'(quotient), 32'd28);
    chk("d200_7_r", 32'(remainder), 32'd4);
    step();

    run_div("dbz13", 8'd13, 8'd0);
    chk("dbz13_q_hold", 32'(quotient), 32'hFF);

    // Back-to-back: start held in the DONE cycle
    launch(8'd5, 8'd9);
    wait_done("b2b1", 1'b0, lat);
    check_result("b2b1", 8'd5, 8'd9);
    dividend = 8'd255; divisor = 8'd1; start = 1'b1;
    step();
    chk("b2b_done_clr", 32'(done), 32'd0);
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_hold_r", 32'(remainder), 32'd5);
    dividend = 8'd77; divisor = 8'd3;   // ignored while in CALC
    step(); step();
    start = 1'b0;
    wait_done("b2b2", 1'b0, lat);
    chk("b2b2_lat", 32'(lat), 32'(W - 2));
    chk("b2b2_q", 32'(quotient), 32'd255);
    chk("b2b2_r", 32'(remainder), 32'd0);
    step();

    // 100/3 with ena low 3 cycles mid-CALC
    launch(8'd100, 8'd3);
    lat = 0;
    for (int k = 0; k < 11 && !done; k++) begin
      ena = !(k >= 3 && k < 6);
      step();
      lat++;
    end
    ena = 1'b1;
    chk("stall_lat", 32'(lat), 32'd11);
    chk("stall_done", 32'(done), 32'd1);
    check_result("stall", 8'd100, 8'd3);
    ena = 1'b0;
    step(); step();
    chk("stall_stretch", 32'(done), 32'd1);
    ena = 1'b1;
    step();
    chk("stall_pulse_end", 32'(done), 32'd0);

    // Reset mid-operation
    launch(8'd200, 8'd7);
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_q", 32'(quotient), 32'd0);
    chk("midrst_r", 32'(remainder), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    for (int k = 0; k < W + 2; k++) begin
      step();
      chk("midrst_nodone", 32'(done), 32'd0);
    end
    run_div("d9_2", 8'd9, 8'd2);

`ifdef DIV_SIGNED_EN
    run_div("s_m100_7", 8'h9C, 8'd7);
    chk("s_m100_7_q", 32'(quotient), 32'hF2);
    chk("s_m100_7_r", 32'(remainder), 32'hFE);
    run_div("s_m128_m1", 8'h80, 8'hFF);
    chk("s_m128_m1_q", 32'(quotient), 32'h80);
`endif

    // Random operands, random ena stalls
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      launch(a, b);
      wait_done("rnd", 1'b1, lat);
      check_result("rnd", a, b);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
